// File: rtl/antirrebote_pulsador_if.sv
// Button-side signal bundle for the push-button debouncer.
// master : whoever drives the raw button and consumes the clean outputs.
// slave  : the debouncer itself.
interface antirrebote_pulsador_if;
  logic puls_ext;  // raw button, active-high, asynchronous, bouncing
  logic pulso;     // one-cycle pulse per accepted press
  logic nivel;     // debounced button level

  modport master (output puls_ext, input pulso, input nivel);
  modport slave  (input puls_ext, output pulso, output nivel);
endinterface

// File: rtl/antirrebote_pulsador.sv
// Push-button debouncer and one-shot generator for the BCD counter board.
// Synchronises the raw button into the clk50MHz domain, waits for DEB_CYC
// consecutive stable samples before accepting a level change, and emits one
// clk50MHz-wide pulse per accepted press.
// Optional feature: define ANTIRREBOTE_AUTOREPEAT_EN to add auto-repeat
// pulses while the button is held (first after REP_DLY cycles in PRESSED,
// then every REP_PER cycles). Without it, exactly one pulse per press.
module antirrebote_pulsador #(
  parameter int DEB_CYC = 1_000_000,
  parameter int REP_DLY = 25_000_000,
  parameter int REP_PER = 5_000_000
) (
  input  logic                   clk50MHz,
  input  logic                   reset,
  antirrebote_pulsador_if.slave  btn
);

  localparam int CW = $clog2(DEB_CYC);
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t CNT_ONE  = cnt_t'(1);
  localparam cnt_t CNT_LAST = cnt_t'(DEB_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  // Reject parameter sets the counters cannot represent.
  if (DEB_CYC < 2) begin : g_bad_deb
    $error("antirrebote_pulsador: DEB_CYC must be >= 2");
  end
  if (REP_PER < 1 || REP_PER > REP_DLY) begin : g_bad_rep
    $error("antirrebote_pulsador: need 1 <= REP_PER <= REP_DLY");
  end

  logic   s1, s;
  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   nivel_q, nivel_d;
  logic   pulso_q, pulso_d;

`ifdef ANTIRREBOTE_AUTOREPEAT_EN
  localparam int RW = $clog2(REP_DLY);
  typedef logic [RW-1:0] rep_t;
  localparam rep_t REP_ONE    = rep_t'(1);
  localparam rep_t REP_LAST   = rep_t'(REP_DLY - 1);
  // Reloading here makes the next terminal count arrive REP_PER cycles later.
  localparam rep_t REP_RELOAD = rep_t'(REP_DLY - REP_PER);
  rep_t rep_q, rep_d;
`endif

  // Two-flop synchroniser for the asynchronous button input.
  // NOTE: every clocked register is written with <= so all flops sample the
  // pre-edge values; blocking = here would collapse s1/s into one stage.
  always_ff @(posedge clk50MHz or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s  <= 1'b0;
    end else begin
      s1 <= btn.puls_ext;
      s  <= s1;
    end
  end

  // Debounce FSM state, stability counter and registered outputs.
  always_ff @(posedge clk50MHz or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      nivel_q <= 1'b0;
      pulso_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nivel_q <= nivel_d;
      pulso_q <= pulso_d;
    end
  end

`ifdef ANTIRREBOTE_AUTOREPEAT_EN
  // Hold-time counter for auto-repeat; only advances while in PRESSED.
  always_ff @(posedge clk50MHz or negedge reset) begin
    if (!reset) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

  // Next-state, counter and output decode for the debounce FSM.
  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    nivel_d = nivel_q;
    pulso_d = 1'b0;
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
    rep_d   = '0;
`endif

    unique case (state_q)
      IDLE: begin
        nivel_d = 1'b0;
        if (s) begin
          state_d = WAIT_PRESS;
          cnt_d   = CNT_ONE;   // this sample is the first stable high
        end
      end

      WAIT_PRESS: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          nivel_d = 1'b1;
          pulso_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      PRESSED: begin
        if (!s) begin
          state_d = WAIT_RELEASE;
          cnt_d   = CNT_ONE;   // this sample is the first stable low
        end
`ifdef ANTIRREBOTE_AUTOREPEAT_EN
        else if (rep_q == REP_LAST) begin
          pulso_d = 1'b1;
          rep_d   = REP_RELOAD;
        end else begin
          rep_d = rep_q + REP_ONE;
        end
`endif
      end

      WAIT_RELEASE: begin
        if (s) begin
          // Release bounce: back to PRESSED without a new pulse.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          nivel_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        nivel_d = 1'b0;
      end
    endcase
  end

  assign btn.pulso = pulso_q;
  assign btn.nivel = nivel_q;

endmodule

// File: tb/tb_antirrebote_pulsador.sv
// Directed bench for antirrebote_pulsador (DEB_CYC=8, REP_DLY=40, REP_PER=10).
// Expected pulse edges are pushed to a scoreboard queue as stimulus is
// driven; every observed pulse (and every expected one) is compared on the
// falling edge. Build with ANTIRREBOTE_AUTOREPEAT_EN to expect repeats.
module tb_antirrebote_pulsador;

  localparam int DEB  = 8;
  localparam int RDLY = 40;
  localparam int RPER = 10;
  localparam int LAT  = DEB + 2;  // from driving edge_cnt N to pulse at N+LAT

`ifdef ANTIRREBOTE_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk50MHz = 1'b0;
  logic reset    = 1'b0;

  antirrebote_pulsador_if bus ();

  antirrebote_pulsador #(
    .DEB_CYC (DEB),
    .REP_DLY (RDLY),
    .REP_PER (RPER)
  ) dut (
    .clk50MHz (clk50MHz),
    .reset    (reset),
    .btn      (bus)
  );

  always #10 clk50MHz = ~clk50MHz;

  int edge_cnt = 0;
  always @(posedge clk50MHz) edge_cnt <= edge_cnt + 1;

  int exp_q[$];
  int errors      = 0;
  int checks      = 0;
  int pulse_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n falling edges, scoring pulso against the expected-edge queue.
  task automatic step(input int n);
    bit hit;
    for (int i = 0; i < n; i++) begin
      @(negedge clk50MHz);
      hit = (exp_q.size() > 0) && (exp_q[0] == edge_cnt);
      if (hit || bus.pulso !== 1'b0) begin
        check($sformatf("pulso_edge%0d", edge_cnt), {31'd0, bus.pulso}, {31'd0, hit});
        if (hit) void'(exp_q.pop_front());
      end
      if (bus.pulso === 1'b1) pulse_total++;
    end
  endtask

  int n, f, r, base;

  initial begin
    bus.puls_ext = 1'b0;

    // Reset state
    repeat (3) @(negedge clk50MHz);
    check("reset_pulso", {31'd0, bus.pulso}, 0);
    check("reset_nivel", {31'd0, bus.nivel}, 0);
    reset = 1'b1;
    step(5);

    // Clean press: 50 high, 50 low
    base = pulse_total;
    n = edge_cnt;
    exp_q.push_back(n + LAT);
    if (AUTO) exp_q.push_back(n + LAT + RDLY);
    bus.puls_ext = 1'b1;
    step(LAT - 1);
    check("clean_nivel_pre", {31'd0, bus.nivel}, 0);
    step(1);
    check("clean_nivel_up", {31'd0, bus.nivel}, 1);
    step(50 - LAT);
    bus.puls_ext = 1'b0;
    step(LAT - 1);
    check("clean_nivel_hold", {31'd0, bus.nivel}, 1);
    step(1);
    check("clean_nivel_down", {31'd0, bus.nivel}, 0);
    step(50 - LAT);
    check("clean_count", pulse_total - base, AUTO ? 2 : 1);
    check("clean_queue", exp_q.size(), 0);

    // Bounce on press: 1x3, 0x2, 1x5, 0x1, then held
    base = pulse_total;
    bus.puls_ext = 1'b1; step(3);
    bus.puls_ext = 1'b0; step(2);
    bus.puls_ext = 1'b1; step(5);
    bus.puls_ext = 1'b0; step(1);
    check("bounce_nivel_pre", {31'd0, bus.nivel}, 0);
    f = edge_cnt;
    exp_q.push_back(f + LAT);
    bus.puls_ext = 1'b1;
    step(LAT - 1);
    check("bounce_nivel_wait", {31'd0, bus.nivel}, 0);
    step(1);
    check("bounce_nivel_up", {31'd0, bus.nivel}, 1);
    step(20);
    bus.puls_ext = 1'b0;
    step(LAT);
    check("bounce_nivel_down", {31'd0, bus.nivel}, 0);
    step(10);
    check("bounce_count", pulse_total - base, 1);

    // Release bounce: 0x4, 1x2, then 0 held
    base = pulse_total;
    n = edge_cnt;
    exp_q.push_back(n + LAT);
    bus.puls_ext = 1'b1;
    step(20);
    bus.puls_ext = 1'b0; step(4);
    check("relb_nivel_low4", {31'd0, bus.nivel}, 1);
    bus.puls_ext = 1'b1; step(2);
    check("relb_nivel_hi2", {31'd0, bus.nivel}, 1);
    f = edge_cnt;
    bus.puls_ext = 1'b0;
    step(LAT - 1);
    check("relb_nivel_hold", {31'd0, bus.nivel}, 1);
    step(1);
    check("relb_nivel_down", {31'd0, bus.nivel}, 0);
    step(10);
    check("relb_count", pulse_total - base, 1);

    // Short glitch: DEB-1 highs must be rejected
    base = pulse_total;
    bus.puls_ext = 1'b1;
    for (int i = 0; i < DEB - 1; i++) begin
      step(1);
      check($sformatf("glitch_nivel_%0d", i), {31'd0, bus.nivel}, 0);
    end
    bus.puls_ext = 1'b0;
    step(15);
    check("glitch_nivel_end", {31'd0, bus.nivel}, 0);
    check("glitch_count", pulse_total - base, 0);

    // Reset at count 5 of WAIT_PRESS, button held throughout
    base = pulse_total;
    bus.puls_ext = 1'b1;
    step(7);
    reset = 1'b0;
    #1;
    check("rstdeb_pulso", {31'd0, bus.pulso}, 0);
    check("rstdeb_nivel", {31'd0, bus.nivel}, 0);
    step(3);
    reset = 1'b1;
    r = edge_cnt;
    exp_q.push_back(r + LAT);
    step(LAT - 1);
    check("rstdeb_nivel_wait", {31'd0, bus.nivel}, 0);
    step(1);
    check("rstdeb_nivel_up", {31'd0, bus.nivel}, 1);
    step(20);
    // Reset while PRESSED clears nivel at once
    reset = 1'b0;
    #1;
    check("rstprs_nivel", {31'd0, bus.nivel}, 0);
    check("rstprs_pulso", {31'd0, bus.pulso}, 0);
    bus.puls_ext = 1'b0;
    step(2);
    reset = 1'b1;
    step(12);
    check("rst_count", pulse_total - base, 1);

    // Long hold: 100 cycles after PRESSED entry
    base = pulse_total;
    n = edge_cnt;
    exp_q.push_back(n + LAT);
    if (AUTO) begin
      exp_q.push_back(n + LAT + RDLY);
      for (int k = 1; k <= 6; k++) exp_q.push_back(n + LAT + RDLY + k * RPER);
    end
    bus.puls_ext = 1'b1;
    step(LAT + 100);
    bus.puls_ext = 1'b0;
    step(20);
    check("hold_count", pulse_total - base, AUTO ? 8 : 1);
    check("hold_nivel_end", {31'd0, bus.nivel}, 0);
    check("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/antirrebote_pulsador.md
# antirrebote_pulsador

Debouncer and one-shot generator for the external push-button of the 4-digit BCD counter board. Sits between the raw pin `puls_ext` and the frequency/button selection mux that clocks the BCD counter. It synchronises the asynchronous button into the `clk50MHz` domain and rejects contact bounce. It emits exactly one `clk50MHz`-wide pulse per clean press, so each press advances the counter by one.

## Interface
Parameters:
- `DEB_CYC`, 1_000_000: consecutive stable synchronised samples required to accept a level change (20 ms at 50 MHz). Legal range ≥ 2.
- `REP_DLY`, 25_000_000: cycles held in PRESSED before the first auto-repeat pulse (500 ms). Used only with the macro.
- `REP_PER`, 5_000_000: cycles between subsequent auto-repeat pulses (100 ms). Used only with the macro.

Ports:
- `clk50MHz` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `puls_ext` input 1: raw button, active-high, asynchronous, bouncing.
- `pulso` output 1: one-cycle press pulse (registered).
- `nivel` output 1: debounced button level (registered).

## Operation
- Two-flop synchroniser: `puls_ext` → `s1` → `s`. Both flops reset to 0. All FSM logic uses only `s`.
- Stability counter width is `$clog2(DEB_CYC)`. It clears on every state transition and on every sample that contradicts the pending level.
- FSM states:
  - IDLE (reset state, `nivel`=0). If `s`=1, go to WAIT_PRESS with counter=1.
  - WAIT_PRESS. If `s`=0, return to IDLE. If `s`=1 and counter=DEB_CYC−1 (DEB_CYC consecutive highs), go to PRESSED, set `nivel`=1, and assert `pulso` for one cycle. Otherwise increment the counter.
  - PRESSED (`nivel`=1). If `s`=0, go to WAIT_RELEASE with counter=1.
  - WAIT_RELEASE (`nivel` stays 1). If `s`=1 (bounce), return to PRESSED with no new pulse. If DEB_CYC consecutive lows, go to IDLE and set `nivel`=0. No pulse on release.
- `pulso` is high for exactly one cycle per IDLE→PRESSED transition. It never stays high for two consecutive cycles.
- A glitch shorter than DEB_CYC samples produces no `pulso` and no `nivel` change.
- Counter saturation and wrap: the counter never exceeds DEB_CYC−1. The terminal-count compare is equality, so there is no wrap-around.
- Asynchronous reset mid-operation:
  - FSM goes to IDLE; counters, `s1`, `s`, `pulso` and `nivel` are all cleared to 0 immediately.
  - A button still held when reset deasserts must complete a full debounce and then produces one `pulso`.

## Timing
- Edge 0 is the first rising edge that samples `puls_ext`=1 with the input stable thereafter.
- Edge 1: `s`=1.
- Edge DEB_CYC+1: `pulso`=1 and `nivel`=1.
- Edge DEB_CYC+2: `pulso`=0.
- Release latency: `nivel` falls at edge DEB_CYC+1, counted from the first edge sampling `puls_ext`=0.
- Reset values: `pulso`=0, `nivel`=0, state=IDLE.
- `reset` deassertion is expected synchronous to `clk50MHz` at board level; the block adds no reset synchroniser.

## Configuration
- Macro: `ANTIRREBOTE_AUTOREPEAT_EN`.
- Defined:
  - A repeat counter of width `$clog2(REP_DLY)` runs while the FSM is in PRESSED.
  - After REP_DLY cycles in PRESSED, one extra one-cycle `pulso` is emitted. Further pulses follow every REP_PER cycles while the button stays in PRESSED.
  - The repeat counter clears on leaving PRESSED.
  - Time spent in WAIT_RELEASE followed by a bounce back to PRESSED restarts the REP_DLY delay.
- Undefined: the repeat logic is absent and exactly one `pulso` is produced per press, regardless of hold time.

## Test plan
Benches use DEB_CYC=8, REP_DLY=40, REP_PER=10.
- Clean press: `puls_ext`=1 held for 50 cycles, then 0 held for 50 → `pulso` high exactly once, at edge 9. `nivel` rises at edge 9 and falls 9 edges after release. Total `pulso` count = 1.
- Bounce on press: 1 for 3 cycles, 0 for 2, 1 for 5, 0 for 1, then 1 held → no pulse before stability. Exactly one `pulso`, 9 edges after the final rising edge.
- Release bounce: while pressed, 0 for 4 cycles, 1 for 2, then 0 held → `nivel` stays 1 through the bounce. No second `pulso`. `nivel` falls 9 edges after the final 0.
- Short glitch: 1 for 7 cycles in IDLE → `pulso`=0 and `nivel`=0 throughout.
- Reset mid-debounce: `reset`=0 asserted at count 5 of WAIT_PRESS while `puls_ext` is held at 1 → outputs 0 immediately. After release of `reset`, `pulso` fires exactly once, 9 edges later.
- Auto-repeat (macro defined): hold for 100 cycles after PRESSED entry → pulses at PRESSED+0, +40, +50, +60, +70, +80, +90, +100. With the macro undefined, the same stimulus gives exactly one pulse.
